// File: rtl/mem_access_unit.sv
// mem_access_unit
// Adapts byte/half/word/dword loads and stores from the MEM stage to a
// doubleword-only data memory (64-bit words, combinational read, write on clk).
// Subword stores are done as read-modify-write. Loads are shifted down to
// their lane, masked to the access size, then sign- or zero-extended.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high and at least one of req_read/req_write is set.
// req_ready is high only in IDLE. Upstream holds the request until it is
// accepted. Each accepted request produces exactly one rsp_valid pulse,
// unless it is cut short by rst.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_*           request from the pipeline (valid/ready, op, size, addr, data)
//   rsp_*           one-cycle response strobe with load data and error flag
//   MemRead/Write   data memory strobes, decoded from the state register only
//   mem_addr        doubleword-aligned memory address
//   mem_wdata       doubleword to write (merged for subword stores)
//   mem_rdata       doubleword read from memory
//   dbg_state       current FSM state (IDLE=0, RD=1, WR=2, RESP=3)
module mem_access_unit #(
    parameter int DW          = 64,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_read,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [DW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [DW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_size;
    logic          r_signed;
    logic          r_write;
    logic          r_err;

    logic          w_accept;
    logic          w_misalign;
    logic          w_req_err;
    logic [2:0]    w_low_mask;
    logic [DW-1:0] w_acc_addr;

    logic [5:0]    w_shamt;
    logic [DW-1:0] w_size_mask;
    logic [DW-1:0] w_lane;
    logic          w_sign;
    logic [DW-1:0] w_load;
    logic [DW-1:0] w_merged;

    // ---------------- request decode ----------------
    assign w_accept = (r_state == S_IDLE) && req_valid && (req_read || req_write);

    always_comb begin
        w_misalign = 1'b0;
        w_low_mask = 3'b000;
        case (req_size)
            2'd0: begin w_misalign = 1'b0;             w_low_mask = 3'b000; end
            2'd1: begin w_misalign = req_addr[0];      w_low_mask = 3'b001; end
            2'd2: begin w_misalign = |req_addr[1:0];   w_low_mask = 3'b011; end
            default: begin w_misalign = |req_addr[2:0]; w_low_mask = 3'b111; end
        endcase
    end

    assign w_req_err  = (req_read && req_write) || (ALIGN_CHECK && w_misalign);
    // Without the alignment check the offset is rounded down to the access size,
    // which also keeps every access inside one doubleword.
    assign w_acc_addr = {req_addr[DW-1:3], req_addr[2:0] & ~w_low_mask};

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_size   <= 2'd0;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr   <= w_acc_addr;
                r_wdata  <= req_wdata;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_write  <= req_write;
                r_err    <= w_req_err;
            end
            if (r_state == S_RD) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)          w_next = S_RESP;
                    else if (req_read)      w_next = S_RD;
                    else if (req_size == 2'd3) w_next = S_WR;
                    else                    w_next = S_RD;  // subword store reads first
                end
            end
            S_RD:    w_next = r_write ? S_WR : S_RESP;
            S_WR:    w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- lane datapath ----------------
    assign w_shamt = {r_addr[2:0], 3'b000};

    always_comb begin
        w_size_mask = '1;
        w_sign      = 1'b0;
        w_lane      = r_rdata >> w_shamt;
        case (r_size)
            2'd0: begin w_size_mask = {{(DW-8){1'b0}},  8'hFF};       w_sign = w_lane[7];  end
            2'd1: begin w_size_mask = {{(DW-16){1'b0}}, 16'hFFFF};    w_sign = w_lane[15]; end
            2'd2: begin w_size_mask = {{(DW-32){1'b0}}, 32'hFFFFFFFF}; w_sign = w_lane[31]; end
            default: begin w_size_mask = '1; w_sign = 1'b0; end
        endcase
    end

    assign w_load   = (w_lane & w_size_mask) |
                      ((r_signed && w_sign) ? ~w_size_mask : '0);
    assign w_merged = (r_rdata & ~(w_size_mask << w_shamt)) |
                      ((r_wdata & w_size_mask) << w_shamt);

    // ---------------- outputs ----------------
    assign req_ready = (r_state == S_IDLE);
    assign MemRead   = (r_state == S_RD);
    assign MemWrite  = (r_state == S_WR);
    assign mem_addr  = {r_addr[DW-1:3], 3'b000};
    assign mem_wdata = (r_state != S_WR) ? '0 :
                       (r_size == 2'd3)  ? r_wdata : w_merged;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_err   = (r_state == S_RESP) && r_err;
    assign rsp_data  = ((r_state == S_RESP) && !r_err && !r_write) ? w_load : '0;
    assign dbg_state = r_state;

endmodule
